// File: rtl/queen_pkg.sv
// Shared types and sizes for the 8-queens enumerator.
package queen_pkg;
    localparam int N     = 8;
    localparam int ROW_W = 3;
    localparam int COL_W = 3;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRY       = 3'd1,
        BACKTRACK = 3'd2,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } state_t;

    typedef logic [N-1:0][COL_W-1:0] board_t;
endpackage

// File: rtl/queen_safe_check.sv
// Combinational attack test of a candidate square against the rows already placed.
module queen_safe_check
    import queen_pkg::*;
(
    input  board_t             board,
    input  logic [ROW_W-1:0]   row,
    input  logic [COL_W-1:0]   col,
    output logic               safe
);
    logic [COL_W:0] col_diff;
    logic [ROW_W:0] row_diff;

    // Differences are one bit wider than the operands so the diagonal test never wraps.
    always_comb begin
        safe     = 1'b1;
        col_diff = '0;
        row_diff = '0;
        for (int i = 0; i < N; i++) begin
            col_diff = (col >= board[i]) ? ({1'b0, col} - {1'b0, board[i]})
                                         : ({1'b0, board[i]} - {1'b0, col});
            row_diff = {1'b0, row} - {1'b0, ROW_W'(i)};
            if ((ROW_W'(i) < row) && ((board[i] == col) || (col_diff == row_diff))) begin
                safe = 1'b0;
            end
        end
    end
endmodule

// File: rtl/queen_solver.sv
// Depth-first 8-queens enumerator: one candidate square or one backtrack step per clock.
//   IDLE | TRY (test cur_col in cur_row) | BACKTRACK (row exhausted, step up) | FOUND | EXHAUSTED
module queen_solver
    import queen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               next,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               probe_en,
    output logic [ROW_W-1:0]   cur_row,
    output logic [COL_W-1:0]   cur_col,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [COL_W-1:0]   rd_col,
    output logic [CNT_W-1:0]   sol_count
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

    state_t             state, state_nxt;
    board_t             board, board_nxt;
    logic [ROW_W-1:0]   row_nxt, prev_row;
    logic [COL_W-1:0]   col_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               safe;

    queen_safe_check u_safe (
        .board (board),
        .row   (cur_row),
        .col   (cur_col),
        .safe  (safe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            board     <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            sol_count <= '0;
        end else begin
            state     <= state_nxt;
            board     <= board_nxt;
            cur_row   <= row_nxt;
            cur_col   <= col_nxt;
            sol_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        board_nxt = board;
        row_nxt   = cur_row;
        col_nxt   = cur_col;
        cnt_nxt   = sol_count;
        prev_row  = cur_row - 1'b1;
        case (state)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) begin
                    board_nxt = '0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = TRY;
                end else if ((state == FOUND) && next) begin
                    // Row 7 has only one legal column once rows 0..6 are fixed.
                    state_nxt = BACKTRACK;
                end
            end
            TRY: begin
                if (safe) begin
                    board_nxt[cur_row] = cur_col;
                    if (cur_row == LAST_ROW) begin
                        cnt_nxt   = sol_count + 1'b1;
                        state_nxt = FOUND;
                    end else begin
                        row_nxt = cur_row + 1'b1;
                        col_nxt = '0;
                    end
                end else if (cur_col == LAST_COL) begin
                    state_nxt = BACKTRACK;
                end else begin
                    col_nxt = cur_col + 1'b1;
                end
            end
            BACKTRACK: begin
                if (cur_row == '0) begin
                    state_nxt = EXHAUSTED;
                end else begin
                    row_nxt = prev_row;
                    if (board[prev_row] != LAST_COL) begin
                        col_nxt   = board[prev_row] + 1'b1;
                        state_nxt = TRY;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == TRY) || (state == BACKTRACK);
    assign found     = (state == FOUND);
    assign exhausted = (state == EXHAUSTED);
    assign probe_en  = (state == TRY);
    assign rd_col    = board[rd_row];
endmodule

// File: tb/tb_queen_solver.sv
// Bench for queen_solver: full enumeration checked against a permutation-based solution list.
module tb_queen_solver;
    typedef logic [7:0][2:0] sol_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       next = 1'b0;
    logic [2:0] rd_row = 3'd0;
    logic       busy, found, exhausted, probe_en;
    logic [2:0] cur_row, cur_col, rd_col;
    logic [6:0] sol_count;

    int   errors = 0;
    int   checks = 0;
    sol_t model[$];
    sol_t last_sol = '0;
    int   found_events = 0;
    int   start_gen = 0;
    int   seen_gen = 0;
    bit   prev_probe = 0, prev_found = 0, prev_exh = 0;
    logic [2:0] prev_row = 3'd0;

    always #20 clk = ~clk;

    queen_solver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .next      (next),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .probe_en  (probe_en),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .sol_count (sol_count)
    );

    function automatic string sol_str(input sol_t s);
        string r = "";
        for (int i = 0; i < 8; i++) r = {r, $sformatf("%0d", s[i])};
        return r;
    endfunction

    function automatic sol_t mk(input int c0, c1, c2, c3, c4, c5, c6, c7);
        sol_t s;
        s[0] = 3'(c0); s[1] = 3'(c1); s[2] = 3'(c2); s[3] = 3'(c3);
        s[4] = 3'(c4); s[5] = 3'(c5); s[6] = 3'(c6); s[7] = 3'(c7);
        return s;
    endfunction

    function automatic bit conflict_free(input sol_t s);
        int d;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++) begin
                d = int'(s[j]) - int'(s[i]);
                if (d < 0) d = -d;
                if (d == 0 || d == j - i) return 0;
            end
        return 1;
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        check(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    task automatic check_sol(input string name, input sol_t act, input sol_t exp);
        check(act == exp, name, sol_str(act), sol_str(exp));
    endtask

    // Every permutation of 0..7 in lexicographic order, kept when no two queens share a diagonal.
    task automatic build_model();
        int   p[8];
        int   i, j, t;
        bit   more;
        sol_t s;
        for (int k = 0; k < 8; k++) p[k] = k;
        more = 1;
        while (more) begin
            for (int k = 0; k < 8; k++) s[k] = 3'(p[k]);
            if (conflict_free(s)) model.push_back(s);
            i = 6;
            while (i >= 0 && p[i] > p[i+1]) i--;
            if (i < 0) more = 0;
            else begin
                j = 7;
                while (p[j] < p[i]) j--;
                t = p[i]; p[i] = p[j]; p[j] = t;
                for (int a = i + 1, b = 7; a < b; a++, b--) begin
                    t = p[a]; p[a] = p[b]; p[b] = t;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        sol_t s;
        if (!rst_n) begin
            prev_probe = 0; prev_found = 0; prev_exh = 0;
        end else begin
            if (seen_gen != start_gen) begin
                seen_gen = start_gen;
                found_events = 0;
            end
            check((int'(busy) + int'(found) + int'(exhausted) <= 1) && (!probe_en || busy),
                  "status_flags", $sformatf("b%0d f%0d e%0d p%0d", busy, found, exhausted, probe_en),
                  "at most one status, probe only while busy");
            if (probe_en && prev_probe)
                check(cur_row >= prev_row, "row_monotonic_in_try",
                      $sformatf("%0d after %0d", cur_row, prev_row), "non-decreasing");
            if (found && !prev_found) begin
                for (int r = 0; r < 8; r++) begin
                    rd_row = 3'(r);
                    #1;
                    s[r] = rd_col;
                end
                check(conflict_free(s), "solution_conflict_free", sol_str(s), "no shared column/diagonal");
                if (found_events < model.size())
                    check_sol($sformatf("solution_%0d", found_events + 1), s, model[found_events]);
                else
                    check(0, "solution_overflow", $sformatf("%0d", found_events + 1), "at most 92");
                check_int("sol_count_at_found", int'(sol_count), found_events + 1);
                found_events++;
                last_sol = s;
            end
            if (exhausted && !prev_exh) begin
                check_int("found_events_at_exhaust", found_events, 92);
                check_int("sol_count_at_exhaust", int'(sol_count), 92);
            end
            prev_probe = probe_en;
            prev_found = found;
            prev_exh   = exhausted;
            prev_row   = cur_row;
        end
    end

    task automatic pulse(input bit s, input bit n);
        @(posedge clk); #1;
        start = s; next = n;
        if (s) start_gen++;
        @(posedge clk); #1;
        start = 0; next = 0;
    endtask

    task automatic wait_found(input int budget);
        bit ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk); #10;
            if (found) ok = 1;
        end
        check(ok, "found_within_budget", "timeout", "found");
    endtask

    task automatic wait_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk); #10;
        end
    endtask

    task automatic check_all_zero(input string name);
        check(!busy && !found && !exhausted && !probe_en && cur_row == 0 && cur_col == 0
              && sol_count == 0 && rd_col == 0, name,
              $sformatf("b%0d f%0d e%0d p%0d row%0d col%0d cnt%0d rd%0d", busy, found, exhausted,
                        probe_en, cur_row, cur_col, sol_count, rd_col), "all zero");
    endtask

    initial begin
        sol_t first_sol, second_sol, last_exp;
        int   cyc;
        first_sol  = mk(0, 4, 7, 5, 2, 6, 1, 3);
        second_sol = mk(0, 5, 7, 2, 6, 3, 1, 4);
        last_exp   = mk(7, 3, 0, 2, 5, 1, 6, 4);

        build_model();
        check_int("model_size", model.size(), 92);
        check_sol("model_first", model[0], first_sol);
        check_sol("model_second", model[1], second_sol);
        check_sol("model_last", model[91], last_exp);

        #5;
        check_all_zero("reset_outputs");
        #25 rst_n = 1'b1;

        pulse(1, 0);
        check(busy && probe_en && cur_row == 0 && cur_col == 0 && sol_count == 0, "busy_after_start",
              $sformatf("b%0d row%0d col%0d cnt%0d", busy, cur_row, cur_col, sol_count), "b1 row0 col0 cnt0");
        wait_found(5000);
        check_int("first_count", int'(sol_count), 1);
        check_sol("first_solution", last_sol, first_sol);

        pulse(0, 1);
        wait_found(5000);
        check_int("second_count", int'(sol_count), 2);
        check_sol("second_solution", last_sol, second_sol);

        cyc = 0;
        while (!exhausted && cyc < 60000) begin
            if (found) begin
                pulse(0, 1);
                cyc += 2;
            end else begin
                wait_cycles(1);
                cyc++;
            end
        end
        check(exhausted == 1'b1, "reach_exhausted", $sformatf("%0d", exhausted), "1");
        check_int("total_found_events", found_events, 92);
        check_int("exhausted_count", int'(sol_count), 92);
        check_sol("last_solution", last_sol, last_exp);

        pulse(0, 1);
        wait_cycles(3);
        check(exhausted && !busy && sol_count == 92, "next_ignored_in_exhausted",
              $sformatf("e%0d b%0d cnt%0d", exhausted, busy, sol_count), "e1 b0 cnt92");

        pulse(1, 0);
        wait_cycles(10);
        pulse(0, 1);
        check(busy == 1'b1, "busy_after_next_in_search", $sformatf("%0d", busy), "1");
        wait_found(5000);
        check_int("count_after_busy_next", int'(sol_count), 1);
        check_sol("solution_after_busy_next", last_sol, first_sol);

        pulse(0, 1);
        wait_cycles(10);
        check(busy == 1'b1, "busy_before_reset", $sformatf("%0d", busy), "1");
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(5);
        check(!busy && !found && !exhausted && sol_count == 0, "idle_after_reset",
              $sformatf("b%0d f%0d e%0d cnt%0d", busy, found, exhausted, sol_count), "b0 f0 e0 cnt0");

        pulse(1, 0);
        wait_found(5000);
        check_int("count_after_reset_restart", int'(sol_count), 1);
        check_sol("solution_after_reset_restart", last_sol, first_sol);

        pulse(0, 1);
        wait_found(5000);
        check_int("count_before_both", int'(sol_count), 2);
        pulse(1, 1);
        check(busy && cur_row == 0 && cur_col == 0 && sol_count == 0, "start_wins_over_next",
              $sformatf("b%0d row%0d col%0d cnt%0d", busy, cur_row, cur_col, sol_count), "b1 row0 col0 cnt0");
        wait_found(5000);
        check_int("count_after_both", int'(sol_count), 1);
        check_sol("solution_after_both", last_sol, first_sol);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/queen_solver.md
QUEEN_SOLVER -- requirements
Module: queen_solver

Interface
REQ-001 Parameters: none; board size fixed at 8x8 (rows/columns indexed 0..7).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  begin a new search from an empty board; sampled per cycle.
REQ-005 next  in  1  resume search for the next solution; sampled per cycle.
REQ-006 busy  out  1  high while searching (TRY or BACKTRACK).
REQ-007 found  out  1  high while a complete solution is held (FOUND).
REQ-008 exhausted  out  1  high when all solutions have been enumerated (EXHAUSTED).
REQ-009 probe_en  out  1  enable to the downstream row decoder; high only in TRY.
REQ-010 cur_row  out  3  row currently being placed.
REQ-011 cur_col  out  3  candidate column in cur_row; binary input to the downstream decoder.
REQ-012 rd_row  in  3  solution readout row select.
REQ-013 rd_col  out  3  stored column for rd_row; combinational read.
REQ-014 sol_count  out  7  solutions found since last start; 0..92.

Function
REQ-015 FSM states: IDLE, TRY, BACKTRACK, FOUND, EXHAUSTED.
REQ-016 start is accepted in IDLE, FOUND or EXHAUSTED: clear board, cur_row=0, cur_col=0, sol_count=0, next state TRY; start is ignored while busy.
REQ-017 TRY, one candidate per cycle: safe = for every placed row i<cur_row, col[i]!=cur_col and |cur_col-col[i]|!=cur_row-i.
REQ-018 TRY, safe and cur_row<7: store col[cur_row]=cur_col, cur_row+1, cur_col=0.
REQ-019 TRY, safe and cur_row==7: store col[7], sol_count+1, go FOUND.
REQ-020 TRY, unsafe and cur_col<7: cur_col+1, stay TRY.
REQ-021 TRY, unsafe and cur_col==7: go BACKTRACK.
REQ-022 BACKTRACK, one row per cycle: if cur_row==0 go EXHAUSTED; else cur_row-1, and if col[cur_row-1]<7 set cur_col=col[cur_row-1]+1 and go TRY, else remain BACKTRACK.
REQ-023 FOUND holds outputs stable; next in FOUND enters BACKTRACK at row 7, as if column 7 had failed there.
REQ-024 start and next asserted together in FOUND: start wins.
REQ-025 next outside FOUND is ignored.
REQ-026 In EXHAUSTED, sol_count holds at 92; only start leaves EXHAUSTED.
REQ-027 Column arithmetic is 3-bit unsigned; the diagonal difference is computed at 4 bits so that no wrap-around occurs.
REQ-028 rd_col reflects the stored column array at all times; it is valid for the full board only in FOUND.

Reset
REQ-029 rst_n low: state IDLE, all outputs 0, column array cleared, sol_count=0, effective immediately and independent of clk.
REQ-030 rst_n asserted mid-search aborts the search; after release, the block waits in IDLE for start.

Structure
REQ-031 Package queen_pkg holds the state enum, N=8, ROW_W=3, COL_W=3 and CNT_W=7.
REQ-032 Combinational sub-module queen_safe_check takes the column array, cur_row and cur_col and outputs safe; queen_solver instantiates it once.

Verification
REQ-033 Reset, then start pulse -> busy=1 next cycle; found rises with rd_col rows 0..7 = 0,4,7,5,2,6,1,3 and sol_count=1.
REQ-034 From first solution, next pulse -> found again with columns 0,5,7,2,6,3,1,4 and sol_count=2.
REQ-035 Repeated next until exhausted -> exactly 92 found events; last solution is 7,3,0,2,5,1,6,4; exhausted=1 and sol_count=92.
REQ-036 Every cycle with probe_en=1, the scoreboard checks that cur_col is 0..7 and that cur_row never decreases during TRY; no found solution contains a column or diagonal conflict.
REQ-037 rst_n pulsed low mid-search (busy=1) -> outputs 0 asynchronously and state IDLE; a following start reproduces the REQ-033 result.
REQ-038 start and next together in FOUND -> restart, sol_count returns to 1 with first solution; next pulsed while busy -> no effect.
